// File: rtl/frb_bram_player.sv
// rtl/frb_bram_player.sv - FRB waveform BRAM playback stage
//
// Plays a waveform stored in a simple-dual-port BRAM at the addresses issued
// by the upstream address counter. The output stream is continuous: it
// carries BRAM words when a sample is due and default_val otherwise.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   wr_en/addr/data   BRAM load port (accepted in every state)
//   rd_addr           playback address from the counter
//   addr_valid        rd_addr is a sample to play this cycle
//   finish            counter issued its last address (rising edge used)
//   default_val       value emitted when no sample is due
//   sample_out        output stream, fixed 2-cycle latency from rd_addr
//   sample_valid      sample_out carries a BRAM word
//   busy              run in progress (PLAY or DRAIN)
//   done              sticky run-complete flag
//   played_count      samples emitted in the current or last run (saturating)
module frb_bram_player #(
  parameter int BRAM_ADDR  = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [BRAM_ADDR-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BRAM_ADDR-1:0]  rd_addr,
  input  logic                  addr_valid,
  input  logic                  finish,
  input  logic [DATA_WIDTH-1:0] default_val,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           played_count
);

  localparam int DEPTH = 1 << BRAM_ADDR;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  v1;
  logic                  finish_d;
  logic                  fin_rise;
  logic                  fin_pend, fin_pend_n;
  logic [1:0]            drain_cnt, drain_cnt_n;
  logic                  start_run;

  // BRAM: no reset so it maps onto block RAM and survives rst. The read
  // samples mem before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_q <= mem[rd_addr];
  end

  assign fin_rise = finish & ~finish_d;

  // Output pipeline: v1 travels alongside rd_q, sample_valid is the second
  // delay stage, so the stream lines up 2 cycles after rd_addr.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1           <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      finish_d     <= 1'b0;
      played_count <= '0;
    end else begin
      v1           <= addr_valid;
      sample_valid <= v1;
      sample_out   <= v1 ? rd_q : default_val;
      finish_d     <= finish;
      // Counting follows sample_valid rather than state so that samples
      // still in flight during DRAIN are included.
      if (start_run) begin
        played_count <= '0;
      end else if (sample_valid && (played_count != 32'hFFFF_FFFF)) begin
        played_count <= played_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= 2'd0;
      fin_pend  <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      fin_pend  <= fin_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    fin_pend_n  = 1'b0;
    start_run   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (addr_valid) begin
          state_n    = S_PLAY;
          start_run  = 1'b1;
          // A finish edge arriving with the first address ends this run;
          // remember it so PLAY moves straight on to DRAIN.
          fin_pend_n = fin_rise;
        end
      end
      S_PLAY: begin
        if (fin_rise || fin_pend) begin
          state_n     = S_DRAIN;
          drain_cnt_n = 2'd2;
        end
      end
      S_DRAIN: begin
        // Leave as the counter reaches zero, so DONE shows up exactly when
        // the last in-flight sample has been emitted and counted.
        if (drain_cnt <= 2'd1) begin
          state_n     = S_DONE;
          drain_cnt_n = 2'd0;
        end else begin
          drain_cnt_n = drain_cnt - 2'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state == S_PLAY) || (state == S_DRAIN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_frb_bram_player.sv
// tb/tb_frb_bram_player.sv - bench for frb_bram_player
module tb_frb_bram_player;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam logic [DW-1:0] DEF = 32'h0000_DEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          addr_valid = 1'b0;
  logic          finish = 1'b0;
  logic [DW-1:0] default_val = DEF;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic [31:0]   played_count;

  frb_bram_player #(.BRAM_ADDR(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .addr_valid   (addr_valid),
    .finish       (finish),
    .default_val  (default_val),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .played_count (played_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } sb_t;

  typedef struct {
    logic          av;
    logic [AW-1:0] ra;
    logic          fin;
    logic          exp_busy;
    logic          exp_done;
    logic [31:0]   exp_cnt;
  } vec_t;

  sb_t           sbq[$];
  vec_t          vecs[$];
  logic [DW-1:0] model_mem [int];
  int            cyc = 0;
  int            zero_cyc = -1;
  bit            mon_en = 1'b0;
  int            tests = 0;
  int            fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input logic av, input logic [AW-1:0] ra, input logic fin,
                         input logic eb, input logic ed, input logic [31:0] ec);
    vec_t v;
    v.av = av; v.ra = ra; v.fin = fin;
    v.exp_busy = eb; v.exp_done = ed; v.exp_cnt = ec;
    vecs.push_back(v);
  endtask

  // Applies one cycle of inputs and updates the scoreboard with what the
  // stream must show two cycles later.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic av, input logic [AW-1:0] ra, input logic fin, input logic r);
    sb_t e;
    @(posedge clk);
    #1;
    wr_en = we; wr_addr = wa; wr_data = wd;
    addr_valid = av; rd_addr = ra; finish = fin; rst = r;
    if (r) begin
      while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
      zero_cyc = cyc + 1;
    end else if (av) begin
      e.due  = cyc + 2;
      e.data = model_mem.exists(int'(ra)) ? model_mem[int'(ra)] : 'x;
      sbq.push_back(e);
    end
    if (we) model_mem[int'(wa)] = wd;
  endtask

  task automatic idle(input logic fin);
    drive(1'b0, '0, '0, 1'b0, '0, fin, 1'b0);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        check("sample_valid", 64'(sample_valid), 64'd1);
        check("sample_out", 64'(sample_out), 64'(e.data));
      end else begin
        check("sample_valid", 64'(sample_valid), 64'd0);
        check("sample_out_idle", 64'(sample_out), (cyc == zero_cyc) ? 64'd0 : 64'(DEF));
      end
    end
  end

  initial begin
    int n;

    // stray finish in IDLE
    add_vec(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec(1'b0, 11'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    // basic run: addresses 0..3, finish level from t+4
    add_vec(1'b1, 11'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec(1'b1, 11'd1, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec(1'b1, 11'd2, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec(1'b1, 11'd3, 1'b0, 1'b1, 1'b0, 32'd1);
    add_vec(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'd2);
    add_vec(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'd3);
    add_vec(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'd4);
    add_vec(1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 32'd4);
    add_vec(1'b0, 11'd0, 1'b1, 1'b0, 1'b1, 32'd4);
    // restart from DONE with 3 samples, finish as a pulse
    add_vec(1'b1, 11'd0, 1'b0, 1'b0, 1'b1, 32'd4);
    add_vec(1'b1, 11'd1, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec(1'b1, 11'd2, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec(1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 32'd1);
    add_vec(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 32'd2);
    add_vec(1'b0, 11'd0, 1'b0, 1'b1, 1'b0, 32'd3);
    add_vec(1'b0, 11'd0, 1'b0, 1'b0, 1'b1, 32'd3);

    repeat (3) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(played_count), 64'd0);

    drive(1'b1, 11'd0, 32'h11, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 11'd1, 32'h22, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 11'd2, 32'h33, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 11'd3, 32'h44, 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, '0, '0, vecs[i].av, vecs[i].ra, vecs[i].fin, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      check($sformatf("vec%0d_count", i), 64'(played_count), 64'(vecs[i].exp_cnt));
    end

    // decimated run: one address every third cycle
    for (int k = 0; k <= 13; k++) begin
      drive(1'b0, '0, '0, (k % 3 == 0) && (k <= 9), 11'(k / 3), k == 10, 1'b0);
      @(negedge clk);
      check($sformatf("dec%0d_busy", k), 64'(busy), (k >= 1 && k <= 12) ? 64'd1 : 64'd0);
    end
    check("dec_done", 64'(done), 64'd1);
    check("dec_count", 64'(played_count), 64'd4);

    // read/write collision on address 5
    drive(1'b1, 11'd5, 32'hAAAA, 1'b0, '0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b1, 11'd5, 32'hBBBB, 1'b1, 11'd5, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 11'd5, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);
    @(negedge clk);
    n = 0;
    while (!done && n < 10) begin
      idle(1'b0);
      @(negedge clk);
      n++;
    end
    check("col_done", 64'(done), 64'd1);
    check("col_count", 64'(played_count), 64'd2);

    // reset after two of four reads
    drive(1'b0, '0, '0, 1'b1, 11'd0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 11'd1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(1'b0);
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_count", 64'(played_count), 64'd0);

    // re-read address 0 with finish on the same cycle as the start
    drive(1'b0, '0, '0, 1'b1, 11'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("same_busy0", 64'(busy), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      idle(1'b0);
      @(negedge clk);
      check($sformatf("same_busy%0d", k), 64'(busy), (k <= 3) ? 64'd1 : 64'd0);
    end
    check("same_done", 64'(done), 64'd1);
    check("same_count", 64'(played_count), 64'd1);

    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frb_bram_player.md
Name: frb_bram_player

Overview:
Playback stage directly downstream of the address counter in the synthetic FRB injector. It holds the FRB waveform in an inferred simple-dual-port BRAM, loaded through a write port. It reads the BRAM at the counter's address whenever the address is flagged valid, and emits a continuous sample stream. When no waveform sample is due, the stream carries the software-set default value. It also tracks run state (idle / playing / draining / done) and counts played samples for register readback.

Parameters:
BRAM_ADDR, 11, read/write address width; memory depth is 2**BRAM_ADDR words.
DATA_WIDTH, 32, sample and default-value width.

Ports:
clk  in  1  single clock for all logic, including both BRAM ports.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  BRAM write strobe.
wr_addr  in  BRAM_ADDR  BRAM write address.
wr_data  in  DATA_WIDTH  BRAM write data.
rd_addr  in  BRAM_ADDR  read address from the address counter (low bits of its 32-bit bus).
addr_valid  in  1  rd_addr is a waveform sample to play this cycle.
finish  in  1  counter has issued its last address (level or pulse; rising edge used).
default_val  in  DATA_WIDTH  value output when no waveform sample is due.
sample_out  out  DATA_WIDTH  continuous output stream.
sample_valid  out  1  sample_out carries a BRAM word this cycle.
busy  out  1  state is PLAY or DRAIN.
done  out  1  sticky; run completed.
played_count  out  32  number of BRAM samples emitted in the current or last run.

Behaviour:
- Reset values: sample_out = 0, sample_valid = 0, busy = 0, done = 0, played_count = 0, state = IDLE.
- Reset does not clear BRAM contents.
- BRAM port A (write): on each clk with wr_en high, mem[wr_addr] <= wr_data. Writes are accepted in every state.
- BRAM port B (read): registered read, rd_q <= mem[rd_addr], every cycle. The read is read-first: a same-cycle write to the same address returns the old word.
- Pipeline: addr_valid is delayed by 2 cycles to match data (v1, then v2).
- Fixed latency of 2 cycles from rd_addr/addr_valid to output:
  - sample_out = rd_q when v2 = 1, else default_val (default_val is registered on the output stage);
  - sample_valid = v2.
- Output is registered; sample_out updates every cycle, including in IDLE and DONE.
- finish edge detect: fin_rise = finish & ~finish_d.
- State machine:
  - IDLE: when addr_valid = 1, go to PLAY, clear played_count, clear done.
  - PLAY: when fin_rise = 1, go to DRAIN and load drain counter with 2.
  - DRAIN: drain counter decrements each cycle; at 0, go to DONE.
  - DONE: done = 1; when addr_valid = 1 (new run), go to PLAY, clear done and played_count.
- busy = 1 in PLAY and DRAIN.
- played_count increments on each cycle with sample_valid = 1, in any state, so that samples still draining are counted. It saturates at 2**32-1.
- fin_rise and addr_valid in the same cycle in IDLE: enter PLAY; the finish is taken as that run's end, so go to DRAIN on the next cycle. fin_rise is held pending for one cycle for this case.
- fin_rise in IDLE or DONE without addr_valid: ignored.
- addr_valid gaps during PLAY (decimation): the output carries default_val in those cycles; state is unaffected.
- Reset mid-run:
  - pipeline valids are cleared, so sample_valid = 0 on the next cycle;
  - state returns to IDLE and counters are cleared;
  - the in-flight samples are dropped.
- Address width: rd_addr and wr_addr are exactly BRAM_ADDR bits; the parent truncates wider buses. No wrap logic is needed here.

Test Plan:
- Load mem[0..3] = 0x11, 0x22, 0x33, 0x44; default_val = 0xDEAD. Drive addr_valid high with rd_addr 0..3 on cycles t..t+3, then finish high at t+4 → sample_valid high t+2..t+5 with 0x11..0x44; sample_out = 0xDEAD elsewhere; done rises at t+7; played_count = 4.
- Decimated run: addr_valid high every 3rd cycle for addresses 0..3 → valid samples spaced 3 cycles apart, 0xDEAD between them, played_count = 4, busy continuously high until drain.
- Read/write collision: mem[5] = 0xAAAA; in the same cycle, write 0xBBBB to address 5 and read address 5 → output 0xAAAA; a read of address 5 one cycle later → output 0xBBBB.
- Reset mid-run: assert rst for 1 cycle after 2 of 4 reads → sample_valid = 0 from the next cycle, busy = 0, played_count = 0, mem contents intact (re-read of address 0 gives 0x11).
- Restart from DONE: after a completed run (done = 1, played_count = 4), assert addr_valid again → done clears, played_count resets and counts the new run (3 samples → 3).
- Stray finish pulse in IDLE with addr_valid low → no state change, done stays 0, busy stays 0.
